// File: rtl/mem_ctrl_pkg.sv
// Shared defaults and FSM state type for the word-array access controller.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  // Wide enough for any SETUP/HOLD/RD_WAIT phase up to 256 cycles.
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WSTROBE = 3'd2,
    WHOLD   = 3'd3,
    RWAIT   = 3'd4,
    RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-request sequencer for an external word array: setup, strobe/hold or read-wait,
// then a held response. All outputs are registered from one FSM block.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int RD_WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_q
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with rsp_valid && rsp_ready; valid never drops before it.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_WAIT - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_we;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_en;
  logic              r_mem_rw;
  logic [DATA_W-1:0] r_mem_din;
  logic              w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_din   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_mem_addr  <= req_addr;
            r_mem_din   <= req_wdata;
            r_cnt       <= SETUP_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (w_cnt_zero) begin
            r_mem_en <= 1'b1;
            if (r_we) begin
              r_mem_rw <= 1'b1;
              r_state  <= WSTROBE;
            end else begin
              r_cnt   <= RD_LOAD;
              r_state <= RWAIT;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        WSTROBE: begin
          r_mem_en <= 1'b0;
          r_mem_rw <= 1'b0;
          r_cnt    <= HOLD_LOAD;
          r_state  <= WHOLD;
        end
        WHOLD: begin
          if (w_cnt_zero) begin
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RWAIT: begin
          if (w_cnt_zero) begin
            // mem_q is combinational off mem_addr, so it is settled by the last wait cycle.
            r_mem_en    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= mem_q;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_mem_en    <= 1'b0;
          r_mem_rw    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_en    = r_mem_en;
  assign mem_rw    = r_mem_rw;
  assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one default-timing instance and one with stretched phases,
// each attached to its own 8x8 array model, checked against a request-level reference.
module tb_mem_access_ctrl;

  localparam int S1 = 3;
  localparam int H1 = 2;
  localparam int R1 = 4;

  logic       clk;
  logic       rst_n;
  logic       init_mem;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [2:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic       rsp_we    [2];
  logic [7:0] rsp_rdata [2];
  logic [2:0] mem_addr  [2];
  logic       mem_en    [2];
  logic       mem_rw    [2];
  logic [7:0] mem_din   [2];
  logic [7:0] mem_q     [2];

  logic [7:0] arr     [2][8];
  logic [7:0] ref_mem [2][8];

  int n_cmp;
  int n_fail;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mem_access_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we[0]),
    .rsp_rdata(rsp_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_en(mem_en[0]), .mem_rw(mem_rw[0]),
    .mem_din(mem_din[0]), .mem_q(mem_q[0])
  );

  mem_access_ctrl #(.SETUP_CYC(S1), .HOLD_CYC(H1), .RD_WAIT(R1)) u_dut_p (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we[1]),
    .rsp_rdata(rsp_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_en(mem_en[1]), .mem_rw(mem_rw[1]),
    .mem_din(mem_din[1]), .mem_q(mem_q[1])
  );

  // ---------------- array models ----------------
  function automatic logic [7:0] init_val(input int d, input int a);
    if (d == 0 && a == 1) return 8'h05;
    return 8'((a * 16) + 8 + d);
  endfunction

  assign mem_q[0] = arr[0][mem_addr[0]];
  assign mem_q[1] = arr[1][mem_addr[1]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (init_mem) begin
        for (int a = 0; a < 8; a++) arr[d][a] <= init_val(d, a);
      end else if (mem_en[d] && mem_rw[d]) begin
        arr[d][mem_addr[d]] <= mem_din[d];
      end
    end
  end

  // A write strobe is always also a select strobe.
  always @(negedge clk) begin
    if (rst_n && !init_mem) begin
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (mem_rw[d] && !mem_en[d]) begin
          n_fail++;
          $display("FAIL rw_without_en d=%0d mem_rw=%b mem_en=%b want mem_en=1", d, mem_rw[d], mem_en[d]);
        end
      end
    end
  end

  // ---------------- timing model ----------------
  function automatic int s_cyc(input int d); return (d == 0) ? 1 : S1; endfunction
  function automatic int h_cyc(input int d); return (d == 0) ? 1 : H1; endfunction
  function automatic int r_cyc(input int d); return (d == 0) ? 2 : R1; endfunction

  // ---------------- driver + inline checks ----------------
  task automatic txn(input int d, input bit we, input logic [2:0] addr, input logic [7:0] data,
                     input int hold);
    int wait_n, lat, en_n, en_first, rw_n, bad_bus;
    int exp_lat, exp_first, exp_en;
    logic [7:0] exp_rd;
    rsp_ready[d] = 1'b0;
    wait_n = 0;
    @(negedge clk);
    while (!req_ready[d] && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    n_cmp++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_wait d=%0d got %b want 1", d, req_ready[d]);
      return;
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = data;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom_range(0, 1));
    req_addr[d]  = 3'($urandom_range(0, 7));
    req_wdata[d] = 8'($urandom_range(0, 255));

    exp_first = s_cyc(d) + 1;
    if (we) begin
      exp_en  = 1;
      exp_lat = s_cyc(d) + 1 + h_cyc(d) + 1;
      exp_rd  = 8'h00;
      ref_mem[d][addr] = data;
    end else begin
      exp_en  = r_cyc(d);
      exp_lat = s_cyc(d) + r_cyc(d) + 1;
      exp_rd  = ref_mem[d][addr];
    end

    lat = 0; en_n = 0; en_first = 0; rw_n = 0; bad_bus = 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid[d] === 1'b1) begin
        lat = k;
      end else begin
        if (mem_en[d] === 1'b1) begin
          en_n++;
          if (en_first == 0) en_first = k;
        end
        if (mem_rw[d] === 1'b1) rw_n++;
        if (mem_addr[d] !== addr || mem_din[d] !== data) bad_bus++;
      end
    end

    n_cmp++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL latency d=%0d we=%0d got %0d want %0d", d, we, lat, exp_lat);
      if (lat == 0) return;
    end
    n_cmp++;
    if (en_n != exp_en || en_first != exp_first) begin
      n_fail++;
      $display("FAIL strobe_window d=%0d we=%0d got %0d cycles from %0d want %0d from %0d",
               d, we, en_n, en_first, exp_en, exp_first);
    end
    n_cmp++;
    if (rw_n != (we ? 1 : 0)) begin
      n_fail++;
      $display("FAIL rw_cycles d=%0d we=%0d got %0d want %0d", d, we, rw_n, we ? 1 : 0);
    end
    n_cmp++;
    if (bad_bus != 0) begin
      n_fail++;
      $display("FAIL bus_stable d=%0d addr/din differed on %0d cycles want 0 (addr=%0d din=%h)",
               d, bad_bus, addr, data);
    end
    n_cmp++;
    if (mem_en[d] !== 1'b0 || mem_rw[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_strobe_off d=%0d en=%b rw=%b want 0 0", d, mem_en[d], mem_rw[d]);
    end
    n_cmp++;
    if (rsp_we[d] !== we || rsp_rdata[d] !== exp_rd) begin
      n_fail++;
      $display("FAIL rsp_data d=%0d addr=%0d got we=%b rdata=%h want we=%b rdata=%h",
               d, addr, rsp_we[d], rsp_rdata[d], we, exp_rd);
    end

    // Stall the response; a competing request must not be taken meanwhile.
    for (int h = 0; h < hold; h++) begin
      req_valid[d] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid[d] !== 1'b1 || rsp_we[d] !== we || rsp_rdata[d] !== exp_rd) begin
        n_fail++;
        $display("FAIL rsp_hold d=%0d cyc=%0d got v=%b we=%b rdata=%h want 1 %b %h",
                 d, h, rsp_valid[d], rsp_we[d], rsp_rdata[d], we, exp_rd);
      end
      n_cmp++;
      if (req_ready[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_in_resp d=%0d cyc=%0d got %b want 0", d, h, req_ready[d]);
      end
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    n_cmp++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake d=%0d got rsp_valid=%b req_ready=%b want 0 1",
               d, rsp_valid[d], req_ready[d]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_we[d] !== 1'b0 ||
          rsp_rdata[d] !== 8'h00 || mem_en[d] !== 1'b0 || mem_rw[d] !== 1'b0 ||
          mem_addr[d] !== 3'd0 || mem_din[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL %s d=%0d got rdy=%b v=%b we=%b rd=%h en=%b rw=%b a=%0d din=%h want 1 0 0 00 0 0 0 00",
                 tag, d, req_ready[d], rsp_valid[d], rsp_we[d], rsp_rdata[d], mem_en[d],
                 mem_rw[d], mem_addr[d], mem_din[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    init_mem = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
      for (int a = 0; a < 8; a++) ref_mem[d][a] = init_val(d, a);
    end
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_directed();
    txn(0, 1'b1, 3'd0, 8'h03, 0);
    txn(0, 1'b0, 3'd1, 8'h00, 0);
    txn(0, 1'b1, 3'd7, 8'hA5, 0);
    txn(0, 1'b0, 3'd7, 8'h3C, 0);
    txn(0, 1'b0, 3'd0, 8'hFF, 0);
  endtask

  task automatic test_backpressure();
    txn(0, 1'b0, 3'd7, 8'h11, 5);
    txn(0, 1'b1, 3'd2, 8'h5A, 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) txn(0, 1'(i & 1), 3'd2, 8'(8'h40 + i), 0);
  endtask

  task automatic test_reset_mid_write();
    int wait_n;
    logic [7:0] old_val;
    old_val = ref_mem[0][3];
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 3'd3; req_wdata[0] = ~old_val;
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_n = 0;
    while (mem_en[0] !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    n_cmp++;
    if (mem_en[0] !== 1'b1 || mem_rw[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_wstrobe got en=%b rw=%b want 1 1", mem_en[0], mem_rw[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_en[0] !== 1'b0 || mem_rw[0] !== 1'b0 || req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort got en=%b rw=%b rdy=%b v=%b want 0 0 1 0",
               mem_en[0], mem_rw[0], req_ready[0], rsp_valid[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || mem_en[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_abort cyc=%0d got v=%b rdy=%b en=%b want 0 1 0",
                 i, rsp_valid[0], req_ready[0], mem_en[0]);
      end
    end
    // The aborted write never completed, so the old word must read back.
    txn(0, 1'b0, 3'd3, 8'h00, 0);
  endtask

  task automatic test_param_timing();
    txn(1, 1'b1, 3'd7, 8'hC3, 1);
    txn(1, 1'b0, 3'd7, 8'h00, 0);
    txn(1, 1'b0, 3'd0, 8'h00, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      txn(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
          int'($urandom_range(0, 3)));
    for (int i = 0; i < 12; i++)
      txn(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
          int'($urandom_range(0, 3)));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_write();
    test_param_timing();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
